water_tile_renderer: RTL and testbench

- Pixel-pipeline reader for the 40x40 8-bit water sprite ROMs.
- Takes the raster pixel stream from the VGA timing block and tiles the water sprite over a rectangular map region.
- Drives the ROM address and frame select (water1/water2), samples ROM data and emits a registered colour with a hit flag to the layer mixer.
- ROM read is combinational: address out, data back in the same cycle.

---
 rtl/water_pkg.sv | 19 +
 rtl/tile_coord_counter.sv | 65 ++++++
 rtl/water_tile_renderer.sv | 128 ++++++++++++
 tb/tb_water_tile_renderer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/water_pkg.sv
// Shared widths and defaults for the water sprite tile renderer.
package water_pkg;

    localparam int unsigned WATER_TILE_W      = 40;
    localparam int unsigned WATER_TILE_H      = 40;
    localparam int unsigned WATER_ANIM_PERIOD = 16;
    localparam int unsigned ROM_ADDR_W        = 11;
    localparam int unsigned COLOR_W           = 8;
    localparam int unsigned PIX_W             = 10;

    localparam logic [COLOR_W-1:0] WATER_TRANSP_KEY = 8'hFF;

    // Stage-1 pipeline qualifiers travelling alongside the ROM address.
    typedef struct packed {
        logic region;
        logic de;
    } stage1_t;

endpackage

// File: rtl/tile_coord_counter.sv
// Tile-local u/v wrap counters plus row-base accumulator; produces v*TILE_W+u
// for the pixel currently on the inputs without a multiplier or divider.
module tile_coord_counter
    import water_pkg::*;
#(
    parameter int unsigned TILE_W = WATER_TILE_W,
    parameter int unsigned TILE_H = WATER_TILE_H
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_de,
    input  logic                  i_row_start,
    input  logic                  i_first_row,
    input  logic                  i_in_region,
    output logic [ROM_ADDR_W-1:0] o_addr_c
);

    localparam int unsigned U_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int unsigned V_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    logic [U_W-1:0]        r_u;
    logic [V_W-1:0]        r_v;
    logic [ROM_ADDR_W-1:0] r_base;

    logic [U_W-1:0]        w_u_cur;
    logic [U_W-1:0]        w_u_next;
    logic [V_W-1:0]        w_v_cur;
    logic [ROM_ADDR_W-1:0] w_base_cur;

    // Coordinates for the current pixel; a row start resolves the new row immediately.
    always_comb begin
        w_u_cur    = i_row_start ? '0 : r_u;
        w_u_next   = (w_u_cur == U_W'(TILE_W - 1)) ? '0 : w_u_cur + U_W'(1);
        w_v_cur    = r_v;
        w_base_cur = r_base;
        if (i_row_start) begin
            if (i_first_row || (r_v == V_W'(TILE_H - 1))) begin
                w_v_cur    = '0;
                w_base_cur = '0;
            end else begin
                w_v_cur    = r_v + V_W'(1);
                w_base_cur = r_base + ROM_ADDR_W'(TILE_W);
            end
        end
        o_addr_c = w_base_cur + ROM_ADDR_W'(w_u_cur);
    end

    // Counter state: u advances on in-region pixels, v/base latch at row start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u    <= '0;
            r_v    <= '0;
            r_base <= '0;
        end else begin
            if (i_de && (i_row_start || i_in_region)) begin
                r_u <= w_u_next;
            end
            if (i_row_start) begin
                r_v    <= w_v_cur;
                r_base <= w_base_cur;
            end
        end
    end

endmodule

// File: rtl/water_tile_renderer.sv
// Water sprite tile renderer: tiles a 40x40 sprite ROM over a map region with a
// two-stage pixel pipeline (address, then colour). Optional frame animation is
// enabled with the WATER_ANIM_EN macro; otherwise rom_frame is fixed at 0.
module water_tile_renderer
    import water_pkg::*;
#(
    parameter int unsigned         TILE_W      = WATER_TILE_W,
    parameter int unsigned         TILE_H      = WATER_TILE_H,
    parameter int unsigned         ORIGIN_X    = 0,
    parameter int unsigned         ORIGIN_Y    = 0,
    parameter int unsigned         GRID_COLS   = 1,
    parameter int unsigned         GRID_ROWS   = 1,
    parameter logic [COLOR_W-1:0]  TRANSP_KEY  = WATER_TRANSP_KEY,
    parameter int unsigned         ANIM_PERIOD = WATER_ANIM_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PIX_W-1:0]      pix_x,
    input  logic [PIX_W-1:0]      pix_y,
    input  logic                  pix_de,
    input  logic                  vsync_pulse,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  rom_frame,
    input  logic [COLOR_W-1:0]    rom_data,
    output logic [COLOR_W-1:0]    pix_color,
    output logic                  pix_hit,
    output logic                  out_valid
);

    localparam int unsigned X_SPAN = GRID_COLS * TILE_W;
    localparam int unsigned Y_SPAN = GRID_ROWS * TILE_H;

    logic                  w_in_region;
    logic                  w_region_de;
    logic                  w_row_start;
    logic                  w_first_row;
    logic                  w_hit;
    logic [ROM_ADDR_W-1:0] w_addr_c;

    logic [ROM_ADDR_W-1:0] r_rom_addr;
    stage1_t               r_s1;
    logic [COLOR_W-1:0]    r_pix_color;
    logic                  r_pix_hit;
    logic                  r_out_valid;

    // Region test via unsigned offset: pixels left of / above the origin wrap to large values.
    always_comb begin
        w_in_region = ((32'(pix_x) - ORIGIN_X) < X_SPAN) && ((32'(pix_y) - ORIGIN_Y) < Y_SPAN);
        w_region_de = pix_de & w_in_region;
        w_row_start = pix_de & (pix_x == PIX_W'(ORIGIN_X));
        w_first_row = (pix_y == PIX_W'(ORIGIN_Y));
        w_hit       = r_s1.region & (rom_data != TRANSP_KEY);
    end

    tile_coord_counter #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H)
    ) u_coord (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_de        (pix_de),
        .i_row_start (w_row_start),
        .i_first_row (w_first_row),
        .i_in_region (w_in_region),
        .o_addr_c    (w_addr_c)
    );

    // Stage 1: register ROM address (held outside region) and delay qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr <= '0;
            r_s1       <= '0;
        end else begin
            r_s1.region <= w_region_de;
            r_s1.de     <= pix_de;
            if (w_region_de) begin
                r_rom_addr <= w_addr_c;
            end
        end
    end

    // Stage 2: sample ROM data and apply the transparency key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_color <= '0;
            r_pix_hit   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_pix_hit   <= w_hit;
            r_pix_color <= w_hit ? rom_data : '0;
            r_out_valid <= r_s1.de;
        end
    end

`ifdef WATER_ANIM_EN
    localparam int unsigned ANIM_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

    logic [ANIM_W-1:0] r_anim_cnt;
    logic              r_rom_frame;

    // Frame animation: toggle sprite frame every ANIM_PERIOD vsync pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anim_cnt  <= '0;
            r_rom_frame <= 1'b0;
        end else if (vsync_pulse) begin
            if (r_anim_cnt == ANIM_W'(ANIM_PERIOD - 1)) begin
                r_anim_cnt  <= '0;
                r_rom_frame <= ~r_rom_frame;
            end else begin
                r_anim_cnt <= r_anim_cnt + ANIM_W'(1);
            end
        end
    end

    assign rom_frame = r_rom_frame;
`else
    logic w_unused_anim;
    assign w_unused_anim = ^{vsync_pulse, 1'(ANIM_PERIOD)};
    assign rom_frame     = 1'b0;
`endif

    assign rom_addr  = r_rom_addr;
    assign pix_color = r_pix_color;
    assign pix_hit   = r_pix_hit;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_water_tile_renderer.sv
// Directed bench for water_tile_renderer: 2x2 tile grid at (100,60), ROM model
// data = addr[7:0] with address 5 holding the transparent key.
module tb_water_tile_renderer;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_de;
    logic        vsync_pulse;
    logic [10:0] rom_addr;
    logic        rom_frame;
    logic [7:0]  rom_data;
    logic [7:0]  pix_color;
    logic        pix_hit;
    logic        out_valid;

    int          checks;
    int          errors;
    int          cur_x;
    int          cur_y;
    int          vs_cnt;
    logic [10:0] exp_addr;
    logic        exp_frame;
    logic [7:0]  prv_color;
    logic        prv_hit;
    logic        prv_valid;

    water_tile_renderer #(
        .TILE_W      (40),
        .TILE_H      (40),
        .ORIGIN_X    (100),
        .ORIGIN_Y    (60),
        .GRID_COLS   (2),
        .GRID_ROWS   (2),
        .TRANSP_KEY  (8'hFF),
        .ANIM_PERIOD (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_de      (pix_de),
        .vsync_pulse (vsync_pulse),
        .rom_addr    (rom_addr),
        .rom_frame   (rom_frame),
        .rom_data    (rom_data),
        .pix_color   (pix_color),
        .pix_hit     (pix_hit),
        .out_valid   (out_valid)
    );

    function automatic logic [7:0] rom_model(input logic [10:0] a);
        return (a == 11'd5) ? 8'hFF : a[7:0];
    endfunction

    assign rom_data = rom_model(rom_addr);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at (%0d,%0d): got %0h expected %0h", tag, cur_x, cur_y, obs, exp);
        end
    endtask

    // One pixel clock: drive inputs, advance the model, check stage-1 and stage-2 outputs.
    task automatic cycle(input int x, input int y, input logic de, input logic vs);
        logic       in_reg;
        logic [7:0] d;
        logic       h;
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        pix_de      = de;
        vsync_pulse = vs;
        cur_x       = x;
        cur_y       = y;
        in_reg = de && (x >= 100) && (x < 180) && (y >= 60) && (y < 140);
        if (in_reg) exp_addr = 11'((((y - 60) % 40) * 40) + ((x - 100) % 40));
`ifdef WATER_ANIM_EN
        if (vs) begin
            vs_cnt++;
            if ((vs_cnt % 4) == 0) exp_frame = ~exp_frame;
        end
`endif
        @(posedge clk);
        #1;
        check("rom_addr", 32'(rom_addr), 32'(exp_addr));
        check("rom_frame", 32'(rom_frame), 32'(exp_frame));
        check("pix_color", 32'(pix_color), 32'(prv_color));
        check("pix_hit", 32'(pix_hit), 32'(prv_hit));
        check("out_valid", 32'(out_valid), 32'(prv_valid));
        d         = rom_model(exp_addr);
        h         = in_reg && (d != 8'hFF);
        prv_color = h ? d : 8'h00;
        prv_hit   = h;
        prv_valid = de;
        @(negedge clk);
    endtask

    // Active pixels x0..x1 on row y followed by one blanking cycle.
    task automatic row(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) cycle(x, y, 1'b1, 1'b0);
        cycle(0, y, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        exp_addr  = '0;
        exp_frame = 1'b0;
        prv_color = '0;
        prv_hit   = 1'b0;
        prv_valid = 1'b0;
        vs_cnt    = 0;
    endtask

    task automatic check_zero_outputs();
        check("rst rom_addr", 32'(rom_addr), 32'd0);
        check("rst rom_frame", 32'(rom_frame), 32'd0);
        check("rst pix_color", 32'(pix_color), 32'd0);
        check("rst pix_hit", 32'(pix_hit), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        pix_de      = 1'b0;
        vsync_pulse = 1'b0;
        checks      = 0;
        errors      = 0;
        cur_x       = 0;
        cur_y       = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check_zero_outputs();
        rst_n = 1'b1;

        // Frame 1: rows above region, full first row, then row starts down to y=140.
        row(58, 99, 101);
        row(59, 99, 101);
        row(60, 98, 181);
        cycle(0, 60, 1'b0, 1'b0);
        cycle(0, 60, 1'b0, 1'b0);
        for (int y = 61; y <= 139; y++) begin
            if (y == 101) begin
                row(101, 99, 120);
                row(101, 121, 142);
            end else begin
                row(y, 99, 101);
            end
        end
        row(140, 99, 101);

        // Frame 2: asynchronous reset mid-row at (120,70).
        for (int y = 58; y <= 69; y++) row(y, 99, 101);
        for (int x = 99; x <= 120; x++) cycle(x, 70, 1'b1, 1'b0);
        pix_de = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero_outputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Frame 3: resume raster after reset.
        row(58, 99, 101);
        row(59, 99, 101);
        row(60, 99, 110);
        row(61, 99, 101);

        // Animation: ten vsync pulses with idle cycles between.
        for (int p = 0; p < 10; p++) begin
            cycle(0, 0, 1'b0, 1'b1);
            cycle(0, 0, 1'b0, 1'b0);
            cycle(0, 0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
